// File: rtl/imem_pkg.sv
// -----------------------------------------------------------------------------
// imem_pkg -- shared definitions for the instruction memory loader core.
//   state_t           : loader/fetch state machine encoding (LOAD, START, RUN)
//   TERM_WORD_DEFAULT : word that ends a program download
//   shift_in_byte()   : big-endian byte assembly helper
// -----------------------------------------------------------------------------
package imem_pkg;

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_START = 2'd1,
        ST_RUN   = 2'd2
    } state_t;

    localparam logic [31:0] TERM_WORD_DEFAULT = 32'hFFFF_FFFF;

    // Shift a new byte into the low end so the first byte received ends up in [31:24].
    function automatic logic [31:0] shift_in_byte(input logic [31:0] acc, input logic [7:0] b);
        return {acc[23:0], b};
    endfunction

endpackage

// File: rtl/imem_bram.sv
// -----------------------------------------------------------------------------
// imem_bram -- single-clock simple dual-port 32-bit RAM, read-first, no reset.
//   clk      : clock
//   i_we     : write enable
//   i_waddr  : write word address
//   i_wdata  : write data
//   i_re     : read enable
//   i_raddr  : read word address
//   o_rdata  : registered read data, holds while i_re is low
// -----------------------------------------------------------------------------
module imem_bram #(
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [31:0]       i_wdata,
    input  logic              i_re,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [31:0]       o_rdata
);

    logic [31:0] r_mem [0:(2**ADDR_W)-1];
    logic [31:0] r_rdata;

    // Storage write and registered read; the read samples the array before the
    // same-edge write lands, which gives read-first behaviour on a collision.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/imem.sv
// -----------------------------------------------------------------------------
// imem -- instruction memory with a byte-stream program loader.
//   clk, rst      : clock, asynchronous active-high reset
//   rx_valid/data : loader byte stream (big-endian words, TERM_WORD ends it)
//   rx_ready      : loader may present a byte (LOAD state only)
//   inst_enable   : fetch read request
//   inst_addr     : fetch word address
//   inst_data     : fetch data, one-cycle latency, NOP until RUN
//   cpu_start     : one-cycle pulse once the program is loaded
//   loaded_words  : words written by the current load
//   overflow      : sticky, program longer than the memory
// -----------------------------------------------------------------------------
module imem
    import imem_pkg::*;
#(
    parameter int          ADDR_W    = 16,
    parameter logic [31:0] TERM_WORD = TERM_WORD_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              rx_ready,
    input  logic              inst_enable,
    input  logic [ADDR_W-1:0] inst_addr,
    output logic [31:0]       inst_data,
    output logic              cpu_start,
    output logic [ADDR_W:0]   loaded_words,
    output logic              overflow
);

    localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

    state_t          r_state;
    state_t          w_state_next;
    logic [1:0]      r_byte_cnt;
    logic [31:0]     r_asm;
    logic [ADDR_W:0] r_loaded_words;
    logic            r_overflow;
    logic            r_rx_ready;
    logic            r_cpu_start;
    logic            r_rd_run;

    logic            w_accept;
    logic [31:0]     w_word;
    logic            w_word_done;
    logic            w_is_term;
    logic            w_full;
    logic            w_we;
    logic [31:0]     w_bram_q;

    // r_rx_ready is only ever high in LOAD, so it alone qualifies the handshake.
    assign w_accept    = rx_valid && r_rx_ready;
    assign w_word      = shift_in_byte(r_asm, rx_data);
    assign w_word_done = w_accept && (r_byte_cnt == 2'd3);
    assign w_is_term   = (w_word == TERM_WORD);
    assign w_full      = (r_loaded_words == DEPTH);
    assign w_we        = w_word_done && !w_is_term && !w_full;

    // Next-state logic: a completed terminator word ends the load.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_LOAD: begin
                if (w_word_done && w_is_term) begin
                    w_state_next = ST_START;
                end else begin
                    w_state_next = ST_LOAD;
                end
            end
            ST_START: w_state_next = ST_RUN;
            ST_RUN:   w_state_next = ST_RUN;
            default:  w_state_next = ST_LOAD;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_LOAD;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Byte assembler; the partial word is dropped once a full word completes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_byte_cnt <= 2'd0;
            r_asm      <= 32'h0000_0000;
        end else if (w_accept) begin
            r_byte_cnt <= r_byte_cnt + 2'd1;
            r_asm      <= w_word_done ? 32'h0000_0000 : w_word;
        end
    end

    // Word counter and sticky overflow; words arriving once the memory is full are discarded.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_loaded_words <= '0;
            r_overflow     <= 1'b0;
        end else begin
            if (w_we) begin
                r_loaded_words <= r_loaded_words + {{ADDR_W{1'b0}}, 1'b1};
            end
            if (w_word_done && !w_is_term && w_full) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // Registered handshake outputs derived from the upcoming state, so both are low during reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rx_ready  <= 1'b0;
            r_cpu_start <= 1'b0;
        end else begin
            r_rx_ready  <= (w_state_next == ST_LOAD);
            r_cpu_start <= (w_state_next == ST_START);
        end
    end

    // Remembers whether the last accepted read was issued in RUN; earlier reads return NOP.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_run <= 1'b0;
        end else if (inst_enable) begin
            r_rd_run <= (r_state == ST_RUN);
        end
    end

    imem_bram #(
        .ADDR_W (ADDR_W)
    ) u_bram (
        .clk     (clk),
        .i_we    (w_we),
        .i_waddr (r_loaded_words[ADDR_W-1:0]),
        .i_wdata (w_word),
        .i_re    (inst_enable),
        .i_raddr (inst_addr),
        .o_rdata (w_bram_q)
    );

    assign inst_data    = r_rd_run ? w_bram_q : 32'h0000_0000;
    assign rx_ready     = r_rx_ready;
    assign cpu_start    = r_cpu_start;
    assign loaded_words = r_loaded_words;
    assign overflow     = r_overflow;

endmodule

// File: tb/tb_imem.sv
// -----------------------------------------------------------------------------
// tb_imem -- self-checking bench for imem (default depth and a 4-word instance)
// plus a direct read-first check of imem_bram.
// -----------------------------------------------------------------------------
module tb_imem;

    logic        clk = 1'b0;
    logic        rst_a;
    logic        rst_b;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        inst_enable;
    logic [15:0] inst_addr;

    logic        a_rx_ready, a_cpu_start, a_overflow;
    logic [31:0] a_inst_data;
    logic [16:0] a_loaded_words;

    logic        b_rx_ready, b_cpu_start, b_overflow;
    logic [31:0] b_inst_data;
    logic [2:0]  b_loaded_words;

    logic        c_we, c_re;
    logic [2:0]  c_waddr, c_raddr;
    logic [31:0] c_wdata, c_rdata;

    logic        sel;
    logic        o_rdy, o_start, o_ovf;
    logic [31:0] o_data;
    logic [16:0] o_words;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] model_mem [int];
    logic [31:0] prog_q [$];

    always #5 clk = ~clk;

    imem #(.ADDR_W(16)) u_a (
        .clk          (clk),
        .rst          (rst_a),
        .rx_valid     (rx_valid),
        .rx_data      (rx_data),
        .rx_ready     (a_rx_ready),
        .inst_enable  (inst_enable),
        .inst_addr    (inst_addr),
        .inst_data    (a_inst_data),
        .cpu_start    (a_cpu_start),
        .loaded_words (a_loaded_words),
        .overflow     (a_overflow)
    );

    imem #(.ADDR_W(2)) u_b (
        .clk          (clk),
        .rst          (rst_b),
        .rx_valid     (rx_valid),
        .rx_data      (rx_data),
        .rx_ready     (b_rx_ready),
        .inst_enable  (inst_enable),
        .inst_addr    (inst_addr[1:0]),
        .inst_data    (b_inst_data),
        .cpu_start    (b_cpu_start),
        .loaded_words (b_loaded_words),
        .overflow     (b_overflow)
    );

    imem_bram #(.ADDR_W(3)) u_c (
        .clk     (clk),
        .i_we    (c_we),
        .i_waddr (c_waddr),
        .i_wdata (c_wdata),
        .i_re    (c_re),
        .i_raddr (c_raddr),
        .o_rdata (c_rdata)
    );

    // Observe whichever imem instance is currently under test.
    always_comb begin
        if (sel) begin
            o_rdy   = b_rx_ready;
            o_start = b_cpu_start;
            o_ovf   = b_overflow;
            o_data  = b_inst_data;
            o_words = {14'd0, b_loaded_words};
        end else begin
            o_rdy   = a_rx_ready;
            o_start = a_cpu_start;
            o_ovf   = a_overflow;
            o_data  = a_inst_data;
            o_words = a_loaded_words;
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic load_checks(input int words_done);
        check("load_rdy",   64'(o_rdy),   64'd1);
        check("load_start", 64'(o_start), 64'd0);
        check("load_words", 64'(o_words), 64'(words_done));
        check("load_nop",   64'(o_data),  64'd0);
    endtask

    // Streams prog_q followed by the terminator with random gaps and random
    // fetch traffic; expected count saturates at the memory depth.
    task automatic load_prog(input int depth);
        int words_done;
        int total;
        words_done = 0;
        total = prog_q.size() + 1;
        for (int w = 0; w < total; w++) begin
            logic [31:0] word;
            word = (w < prog_q.size()) ? prog_q[w] : 32'hFFFF_FFFF;
            for (int b = 0; b < 4; b++) begin
                repeat ($urandom_range(0, 2)) begin
                    rx_valid    = 1'b0;
                    rx_data     = 8'($urandom);
                    inst_enable = 1'($urandom);
                    inst_addr   = 16'($urandom);
                    tick();
                    load_checks(words_done);
                end
                rx_valid    = 1'b1;
                rx_data     = word[31-8*b -: 8];
                inst_enable = 1'($urandom);
                inst_addr   = 16'($urandom_range(0, 7));
                tick();
                rx_valid = 1'b0;
                if (b == 3 && w < prog_q.size() && words_done < depth) begin
                    words_done++;
                end
                if (!(b == 3 && w == total - 1)) begin
                    load_checks(words_done);
                end
            end
        end
        check("start_pulse", 64'(o_start), 64'd1);
        check("start_rdy",   64'(o_rdy),   64'd0);
        check("start_words", 64'(o_words), 64'(words_done));
        check("start_ovf",   64'(o_ovf),   64'(prog_q.size() > depth));
        inst_enable = 1'b1;
        inst_addr   = 16'd0;
        tick();
        inst_enable = 1'b0;
        check("start_nop",   64'(o_data),  64'd0);
        check("start_once",  64'(o_start), 64'd0);
        check("run_rdy",     64'(o_rdy),   64'd0);
    endtask

    initial begin
        int k;
        logic [31:0] exp_d;
        logic [31:0] w;

        rst_a = 1'b1; rst_b = 1'b1; sel = 1'b0;
        rx_valid = 1'b0; rx_data = 8'd0; inst_enable = 1'b1; inst_addr = 16'd0;
        c_we = 1'b0; c_re = 1'b0; c_waddr = 3'd0; c_raddr = 3'd0; c_wdata = 32'd0;
        repeat (3) tick();

        // Reset values of both instances
        check("rst_data",  64'(a_inst_data),    64'd0);
        check("rst_rdy",   64'(a_rx_ready),     64'd0);
        check("rst_start", 64'(a_cpu_start),    64'd0);
        check("rst_words", 64'(a_loaded_words), 64'd0);
        check("rst_ovf",   64'(a_overflow),     64'd0);
        check("rst_b_rdy", 64'(b_rx_ready),     64'd0);

        rst_a = 1'b0;
        inst_enable = 1'b0;
        check("rdy_at_release", 64'(a_rx_ready), 64'd0);
        tick();
        check("rdy_after_release", 64'(a_rx_ready), 64'd1);

        // Partial word then reset: the partial bytes must be lost
        rx_valid = 1'b1; rx_data = 8'hAB; tick();
        rx_data = 8'hCD; tick();
        rx_valid = 1'b0;
        #2 rst_a = 1'b1;
        #1;
        check("midload_rst_words", 64'(a_loaded_words), 64'd0);
        check("midload_rst_rdy",   64'(a_rx_ready),     64'd0);
        @(negedge clk);
        rst_a = 1'b0;
        tick();

        // Main program: word 0 fixed, word 5 fixed, rest random
        k = $urandom_range(6, 12);
        prog_q.delete();
        for (int i = 0; i < k; i++) begin
            w = $urandom;
            if (w == 32'hFFFF_FFFF) w = 32'h0;
            if (i == 0) w = 32'h1234_5678;
            if (i == 5) w = 32'hAABB_CCDD;
            prog_q.push_back(w);
        end
        load_prog(65536);
        for (int i = 0; i < k; i++) model_mem[i] = prog_q[i];

        // RUN ignores the loader
        repeat (3) begin
            rx_valid = 1'b1; rx_data = 8'($urandom);
            tick();
            check("run_rdy_low",  64'(a_rx_ready),     64'd0);
            check("run_words",    64'(a_loaded_words), 64'(k));
            check("run_no_start", 64'(a_cpu_start),    64'd0);
        end
        rx_valid = 1'b0;

        inst_enable = 1'b1; inst_addr = 16'd0; tick();
        check("read_addr0", 64'(a_inst_data), 64'h1234_5678);
        inst_enable = 1'b0; inst_addr = 16'd1; tick();
        check("read_hold", 64'(a_inst_data), 64'h1234_5678);
        inst_enable = 1'b1; inst_addr = 16'd5; tick();
        check("read_addr5", 64'(a_inst_data), 64'hAABB_CCDD);

        exp_d = 32'hAABB_CCDD;
        repeat (30) begin
            inst_enable = 1'($urandom);
            inst_addr   = 16'($urandom_range(0, k - 1));
            if (inst_enable) exp_d = model_mem[int'(inst_addr)];
            tick();
            check("read_rand", 64'(a_inst_data), 64'(exp_d));
        end

        // Reload a shorter program; words above it must survive reset
        inst_enable = 1'b0;
        #2 rst_a = 1'b1;
        @(negedge clk);
        check("rerst_data", 64'(a_inst_data), 64'd0);
        rst_a = 1'b0;
        tick();
        prog_q.delete();
        for (int i = 0; i < 2; i++) begin
            w = $urandom;
            if (w == 32'hFFFF_FFFF) w = 32'h1;
            prog_q.push_back(w);
            model_mem[i] = w;
        end
        load_prog(65536);
        for (int i = 0; i < k; i++) begin
            inst_enable = 1'b1; inst_addr = 16'(i);
            tick();
            check("reload_read", 64'(a_inst_data), 64'(model_mem[i]));
        end
        inst_enable = 1'b0;

        // Overflow on the 4-word instance
        sel = 1'b1;
        rst_b = 1'b0;
        tick();
        prog_q.delete();
        for (int i = 0; i < 5; i++) begin
            w = $urandom;
            if (w == 32'hFFFF_FFFF) w = 32'h2;
            prog_q.push_back(w);
        end
        load_prog(4);
        check("ovf_sticky", 64'(o_ovf), 64'd1);
        for (int i = 0; i < 4; i++) begin
            inst_enable = 1'b1; inst_addr = 16'(i);
            tick();
            check("ovf_read", 64'(o_data), 64'(prog_q[i]));
        end
        inst_enable = 1'b0;

        // Read-first collision on the RAM itself
        c_we = 1'b1; c_waddr = 3'd5; c_wdata = 32'h1111_1111;
        tick();
        c_wdata = 32'hAABB_CCDD; c_re = 1'b1; c_raddr = 3'd5;
        tick();
        c_we = 1'b0;
        check("bram_read_first", 64'(c_rdata), 64'h1111_1111);
        tick();
        check("bram_read_new", 64'(c_rdata), 64'hAABB_CCDD);
        c_re = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
